// File: rtl/alu_mon_pkg.sv
// Shared constants for the ALU lockstep monitor: opcode encoding of the
// monitored ALU pair and the monitor state encoding.
package alu_mon_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] ALARM    = 2'd2;

endpackage

// File: rtl/alu_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear. Holds at all-ones and
// never wraps, so a long-running monitor cannot alias back to small counts.
module alu_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at the maximum value; clr wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_lockstep_monitor.sv
// Runtime lockstep monitor comparing a golden ALU against a suspect ALU.
// Counts tested transactions, mismatches and known trigger patterns, and
// raises a sticky alarm once the mismatch count reaches ALARM_THRESH.
// Build option: define ALU_MON_CAPTURE_EN to build the first-mismatch
// capture registers; otherwise cap_valid and cap_* are tied to 0.
//
// state    | meaning
// DISARMED | idle after reset/clear, all inputs ignored
// ARMED    | counting transactions, mismatches below threshold
// ALARM    | threshold reached, still counting, left only by clear/reset
module alu_lockstep_monitor
  import alu_mon_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 1,
  parameter int CMP_FLAGS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] gold_result,
  input  logic             gold_carry,
  input  logic             gold_zero,
  input  logic [WIDTH-1:0] dut_result,
  input  logic             dut_carry,
  input  logic             dut_zero,
  output logic             armed,
  output logic             alarm,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] trigger_count,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic [1:0]       cap_op,
  output logic [WIDTH+1:0] cap_gold,
  output logic [WIDTH+1:0] cap_dut
);

  // Mismatch count one below the threshold: the next counted mismatch
  // reaches it. Saturation is harmless since ALARM_THRESH <= counter max.
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(ALARM_THRESH - 1);

  logic [1:0] state, state_nxt;
  logic       counted;
  logic       flag_diff;
  logic       mismatch;
  logic       trigger_hit;

  // Classify the current sample: counted, mismatching, trigger pattern.
  always_comb begin
    counted     = in_valid && (state != DISARMED);
    flag_diff   = (CMP_FLAGS != 0) &&
                  ((gold_carry != dut_carry) || (gold_zero != dut_zero));
    mismatch    = counted && ((gold_result != dut_result) || flag_diff);
    trigger_hit = counted &&
                  (((in_a == '1) && (in_b == '1) && (in_op == OP_ADD)) ||
                   ((in_a == '0) && (in_b == '1) && (in_op == OP_AND)));
  end

  // Next-state decode; clear overrides everything, ALARM is sticky.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = DISARMED;
    end else begin
      case (state)
        DISARMED: if (arm) state_nxt = ARMED;
        ARMED:    if (mismatch && (mismatch_count >= THRESH_M1)) state_nxt = ALARM;
        ALARM:    state_nxt = ALARM;
        default:  state_nxt = DISARMED;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISARMED;
    else        state <= state_nxt;
  end

  // One-cycle pulse per counted mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mismatch_pulse <= 1'b0;
    else if (clear) mismatch_pulse <= 1'b0;
    else            mismatch_pulse <= mismatch;
  end

  assign armed = (state == ARMED) || (state == ALARM);
  assign alarm = (state == ALARM);

  alu_mon_sat_cnt #(.W(CNT_W)) u_test_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(counted), .count(test_count)
  );

  alu_mon_sat_cnt #(.W(CNT_W)) u_mis_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(mismatch), .count(mismatch_count)
  );

  alu_mon_sat_cnt #(.W(CNT_W)) u_trig_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(trigger_hit), .count(trigger_count)
  );

`ifdef ALU_MON_CAPTURE_EN
  // Freeze operands and both ALU outputs of the first counted mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      cap_gold  <= '0;
      cap_dut   <= '0;
    end else if (clear) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_op    <= '0;
      cap_gold  <= '0;
      cap_dut   <= '0;
    end else if (mismatch && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_a     <= in_a;
      cap_b     <= in_b;
      cap_op    <= in_op;
      cap_gold  <= {gold_carry, gold_zero, gold_result};
      cap_dut   <= {dut_carry, dut_zero, dut_result};
    end
  end
`else
  assign cap_valid = 1'b0;
  assign cap_a     = '0;
  assign cap_b     = '0;
  assign cap_op    = '0;
  assign cap_gold  = '0;
  assign cap_dut   = '0;
`endif

endmodule

// File: tb/tb_alu_lockstep_monitor.sv
// Directed bench for alu_lockstep_monitor. Three instances share one
// stimulus stream: d3 (threshold 3, flags compared), d1 (threshold 1,
// result-only compare) and ds (3-bit counters for saturation).
module tb_alu_lockstep_monitor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             arm = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [1:0]       in_op = '0;
  logic [WIDTH-1:0] gold_result = '0, dut_result = '0;
  logic             gold_carry = 1'b0, gold_zero = 1'b0;
  logic             dut_carry = 1'b0, dut_zero = 1'b0;

  logic             d3_armed, d3_alarm, d3_pulse, d3_capv;
  logic [15:0]      d3_test, d3_mis, d3_trig;
  logic [WIDTH-1:0] d3_cap_a, d3_cap_b;
  logic [1:0]       d3_cap_op;
  logic [WIDTH+1:0] d3_cap_gold, d3_cap_dut;

  logic             d1_armed, d1_alarm, d1_pulse, d1_capv;
  logic [15:0]      d1_test, d1_mis, d1_trig;
  logic [WIDTH-1:0] d1_cap_a, d1_cap_b;
  logic [1:0]       d1_cap_op;
  logic [WIDTH+1:0] d1_cap_gold, d1_cap_dut;

  logic             ds_armed, ds_alarm, ds_pulse, ds_capv;
  logic [2:0]       ds_test, ds_mis, ds_trig;
  logic [WIDTH-1:0] ds_cap_a, ds_cap_b;
  logic [1:0]       ds_cap_op;
  logic [WIDTH+1:0] ds_cap_gold, ds_cap_dut;

  int errors = 0;
  int checks = 0;

  alu_lockstep_monitor #(.WIDTH(WIDTH), .CNT_W(16), .ALARM_THRESH(3), .CMP_FLAGS(1)) d3 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .gold_result(gold_result), .gold_carry(gold_carry), .gold_zero(gold_zero),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .armed(d3_armed), .alarm(d3_alarm), .mismatch_pulse(d3_pulse),
    .test_count(d3_test), .mismatch_count(d3_mis), .trigger_count(d3_trig),
    .cap_valid(d3_capv), .cap_a(d3_cap_a), .cap_b(d3_cap_b), .cap_op(d3_cap_op),
    .cap_gold(d3_cap_gold), .cap_dut(d3_cap_dut)
  );

  alu_lockstep_monitor #(.WIDTH(WIDTH), .CNT_W(16), .ALARM_THRESH(1), .CMP_FLAGS(0)) d1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .gold_result(gold_result), .gold_carry(gold_carry), .gold_zero(gold_zero),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .armed(d1_armed), .alarm(d1_alarm), .mismatch_pulse(d1_pulse),
    .test_count(d1_test), .mismatch_count(d1_mis), .trigger_count(d1_trig),
    .cap_valid(d1_capv), .cap_a(d1_cap_a), .cap_b(d1_cap_b), .cap_op(d1_cap_op),
    .cap_gold(d1_cap_gold), .cap_dut(d1_cap_dut)
  );

  alu_lockstep_monitor #(.WIDTH(WIDTH), .CNT_W(3), .ALARM_THRESH(1), .CMP_FLAGS(1)) ds (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .gold_result(gold_result), .gold_carry(gold_carry), .gold_zero(gold_zero),
    .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .armed(ds_armed), .alarm(ds_alarm), .mismatch_pulse(ds_pulse),
    .test_count(ds_test), .mismatch_count(ds_mis), .trigger_count(ds_trig),
    .cap_valid(ds_capv), .cap_a(ds_cap_a), .cap_b(ds_cap_b), .cap_op(ds_cap_op),
    .cap_gold(ds_cap_gold), .cap_dut(ds_cap_dut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one sample, clock it in, land 1 ns after the edge.
  task automatic txn(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                     input logic [3:0] gr, input logic gc, input logic gz,
                     input logic [3:0] dr, input logic dc, input logic dz);
    in_valid = v; in_a = a; in_b = b; in_op = op;
    gold_result = gr; gold_carry = gc; gold_zero = gz;
    dut_result = dr; dut_carry = dc; dut_zero = dz;
    @(posedge clk); #1;
    in_valid = 1'b0; arm = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_armed", 32'(d3_armed), 0);
    chk("rst_alarm", 32'(d3_alarm), 0);
    chk("rst_pulse", 32'(d3_pulse), 0);
    chk("rst_test", 32'(d3_test), 0);
    chk("rst_capv", 32'(d3_capv), 0);

    // Disarmed: mismatching valid samples are ignored.
    for (int i = 0; i < 5; i++) txn(1, 4'h3, 4'h5, 2'b01, 4'hE, 1, 0, 4'hF, 1, 0);
    chk("dis_test", 32'(d3_test), 0);
    chk("dis_mis", 32'(d3_mis), 0);
    chk("dis_alarm", 32'(d1_alarm), 0);
    chk("dis_pulse", 32'(d3_pulse), 0);

    // Arm with a simultaneous mismatch: that sample is not counted.
    arm = 1'b1;
    txn(1, 4'h3, 4'h5, 2'b01, 4'hE, 1, 0, 4'hF, 1, 0);
    chk("arm_armed", 32'(d3_armed), 1);
    chk("arm_test", 32'(d3_test), 0);
    chk("arm_mis", 32'(d1_mis), 0);

    // Trigger pattern 1111+1111 ADD, matching outputs.
    for (int i = 0; i < 10; i++) txn(1, 4'hF, 4'hF, 2'b00, 4'hE, 1, 0, 4'hE, 1, 0);
    chk("trig_test", 32'(d3_test), 10);
    chk("trig_trig", 32'(d3_trig), 10);
    chk("trig_mis", 32'(d3_mis), 0);
    chk("trig_capv", 32'(d3_capv), 0);
    chk("sat_test", 32'(ds_test), 7);
    chk("sat_trig", 32'(ds_trig), 7);

    // First mismatch: 0000 AND 1111, gold 0000 z=1, dut 0001 z=0.
    txn(1, 4'h0, 4'hF, 2'b10, 4'h0, 0, 1, 4'h1, 0, 0);
    chk("m1_mis", 32'(d3_mis), 1);
    chk("m1_pulse", 32'(d3_pulse), 1);
    chk("m1_alarm", 32'(d3_alarm), 0);
    chk("m1_trig", 32'(d3_trig), 11);
    chk("th1_alarm", 32'(d1_alarm), 1);
`ifdef ALU_MON_CAPTURE_EN
    chk("m1_capv", 32'(d3_capv), 1);
    chk("th1_capv", 32'(d1_capv), 1);
`else
    chk("m1_capv", 32'(d3_capv), 0);
    chk("th1_capv", 32'(d1_capv), 0);
`endif

    txn(1, 4'h5, 4'h3, 2'b00, 4'h8, 0, 0, 4'h9, 0, 0);
    chk("m2_mis", 32'(d3_mis), 2);
    chk("m2_pulse", 32'(d3_pulse), 1);
    chk("m2_alarm", 32'(d3_alarm), 0);

    txn(1, 4'h6, 4'h2, 2'b01, 4'h4, 0, 0, 4'h6, 0, 0);
    chk("m3_mis", 32'(d3_mis), 3);
    chk("m3_alarm", 32'(d3_alarm), 1);
`ifdef ALU_MON_CAPTURE_EN
    chk("cap_a", 32'(d3_cap_a), 32'h0);
    chk("cap_b", 32'(d3_cap_b), 32'hF);
    chk("cap_op", 32'(d3_cap_op), 32'h2);
    chk("cap_gold", 32'(d3_cap_gold), 32'h10);
    chk("cap_dut", 32'(d3_cap_dut), 32'h01);
`else
    chk("cap_a", 32'(d3_cap_a), 0);
    chk("cap_dut", 32'(d3_cap_dut), 0);
`endif

    // Idle: pulse drops, alarm stays.
    txn(0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("idle_pulse", 32'(d3_pulse), 0);
    chk("idle_alarm", 32'(d3_alarm), 1);
    chk("idle_test", 32'(d3_test), 13);

    // Carry-only difference: counted only where flags are compared.
    txn(1, 4'h1, 4'h2, 2'b00, 4'h3, 0, 0, 4'h3, 1, 0);
    chk("flag_mis_cmp", 32'(d3_mis), 4);
    chk("flag_pulse_cmp", 32'(d3_pulse), 1);
    chk("flag_mis_nocmp", 32'(d1_mis), 3);
    chk("flag_pulse_nocmp", 32'(d1_pulse), 0);
    chk("flag_test", 32'(d3_test), 14);

    // Clear with arm and a mismatch in the same cycle, while in ALARM.
    clear = 1'b1; arm = 1'b1;
    txn(1, 4'hF, 4'hF, 2'b00, 4'h0, 0, 1, 4'h1, 0, 0);
    chk("clr_armed", 32'(d3_armed), 0);
    chk("clr_alarm", 32'(d3_alarm), 0);
    chk("clr_pulse", 32'(d3_pulse), 0);
    chk("clr_test", 32'(d3_test), 0);
    chk("clr_mis", 32'(d3_mis), 0);
    chk("clr_trig", 32'(d3_trig), 0);
    chk("clr_capv", 32'(d3_capv), 0);
    chk("clr_cap_b", 32'(d3_cap_b), 0);

    txn(1, 4'h1, 4'h1, 2'b00, 4'h2, 0, 0, 4'h3, 0, 0);
    chk("post_clr_test", 32'(d3_test), 0);

    arm = 1'b1;
    txn(0, 4'h0, 4'h0, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0);
    arm = 1'b1;
    txn(1, 4'h1, 4'h1, 2'b00, 4'h2, 0, 0, 4'h2, 0, 0);
    chk("rearm_armed", 32'(d3_armed), 1);
    chk("rearm_alarm", 32'(d3_alarm), 0);
    txn(1, 4'h1, 4'h1, 2'b00, 4'h2, 0, 0, 4'h2, 0, 0);
    chk("rearm_test", 32'(d3_test), 2);

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_test", 32'(d3_test), 0);
    chk("arst_armed", 32'(d3_armed), 0);
    #10 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
